// File: rtl/gppcu_alu_seq_pkg.sv
// Shared definitions for the registered GPPCU ALU: opcode map, flag bit positions,
// shifter sub-op and sequencer state encodings.
// No logic; imported by gppcu_alu_seq and gppcu_barrel_shift.
package gppcu_alu_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MOV = 4'd1;
    localparam logic [3:0] OP_MVN = 4'd2;
    localparam logic [3:0] OP_ADC = 4'd3;
    localparam logic [3:0] OP_SBC = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_ORR = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_ADI = 4'd8;
    localparam logic [3:0] OP_SBI = 4'd9;
    localparam logic [3:0] OP_MVI = 4'd10;
    localparam logic [3:0] OP_LSL = 4'd11;
    localparam logic [3:0] OP_LSR = 4'd12;
    localparam logic [3:0] OP_ASR = 4'd13;
    localparam logic [3:0] OP_MUL = 4'd14;
    localparam logic [3:0] OP_ROR = 4'd15;

    // Bit positions inside the 4-bit NZCV flag register
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } sh_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/gppcu_barrel_shift.sv
// Barrel shifter for LSL/LSR/ASR/ROR by a variable amount, with carry-out.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: a_i operand, n_i shift amount, op_i sub-op, c_i carry passed through when
//        n_i==0; q_o result, c_o last bit shifted out (ROR: result MSB).
module gppcu_barrel_shift
    import gppcu_alu_seq_pkg::*;
#(
    parameter int BW = 32,
    parameter int SW = $clog2(BW)
) (
    input  logic [BW-1:0] a_i,
    input  logic [SW-1:0] n_i,
    input  sh_op_e        op_i,
    input  logic          c_i,
    output logic [BW-1:0] q_o,
    output logic          c_o
);

    // One guard bit beyond the data catches the last bit shifted out
    logic [BW:0]   lsl_w;
    logic [BW:0]   lsr_w;
    logic [BW:0]   asr_w;
    logic [BW-1:0] ror_w;

    always_comb begin
        lsl_w = {1'b0, a_i} << n_i;
        lsr_w = {a_i, 1'b0} >> n_i;
        asr_w = $signed({a_i, 1'b0}) >>> n_i;
        // n_i==0 makes the left term shift by BW, which yields zero
        ror_w = (a_i >> n_i) | (a_i << (BW - n_i));

        q_o = ror_w;
        c_o = ror_w[BW-1];
        case (op_i)
            SH_LSL: begin q_o = lsl_w[BW-1:0]; c_o = lsl_w[BW]; end
            SH_LSR: begin q_o = lsr_w[BW:1];   c_o = lsr_w[0];  end
            SH_ASR: begin q_o = asr_w[BW:1];   c_o = asr_w[0];  end
            default: ;
        endcase

        // A zero-length shift leaves the architectural carry untouched
        if (n_i == '0) begin
            c_o = c_i;
        end
    end

endmodule

// File: rtl/gppcu_alu_seq.sv
// Registered handshaked GPPCU ALU with NZCV flag register; optional MUL via GPPCU_ALU_MUL_EN.
// Latency 1 cycle for all ops (BW+1 for MUL when enabled); throughput 1 op/cycle.
// Backpressure: oQ/oVALID hold while oVALID & ~iREADY; oREADY low then and during MUL.
// Ports: iVALID/oREADY/iOP/iA/iB/iSETF upstream op; oVALID/iREADY/oQ downstream result;
//        oN/oZ/oC/oV flag register; oBUSY high while a multiply iterates.
module gppcu_alu_seq
    import gppcu_alu_seq_pkg::*;
#(
    parameter int BW = 32,
    parameter int SW = $clog2(BW)
) (
    input  logic          iCLK,
    input  logic          iNRST,
    input  logic          iVALID,
    output logic          oREADY,
    input  logic [3:0]    iOP,
    input  logic [BW-1:0] iA,
    input  logic [BW-1:0] iB,
    input  logic          iSETF,
    output logic          oVALID,
    input  logic          iREADY,
    output logic [BW-1:0] oQ,
    output logic          oN,
    output logic          oZ,
    output logic          oC,
    output logic          oV,
    output logic          oBUSY
);

    logic [BW-1:0] q_q;
    logic          vld_q;
    logic [3:0]    flags_q;

    logic          accept;
    logic [BW:0]   add_w;
    logic [BW:0]   sub_w;
    logic          cin_add;
    logic          cin_sub;
    logic [BW-1:0] alu_q;
    logic          alu_c;
    logic          alu_v;
    logic [3:0]    flags_d;
    logic [BW-1:0] sh_q;
    logic          sh_c;
    sh_op_e        sh_op;

    always_comb begin
        case (iOP)
            OP_LSL:  sh_op = SH_LSL;
            OP_LSR:  sh_op = SH_LSR;
            OP_ASR:  sh_op = SH_ASR;
            default: sh_op = SH_ROR;
        endcase
    end

    gppcu_barrel_shift #(.BW(BW), .SW(SW)) u_shift (
        .a_i  (iA),
        .n_i  (iB[SW-1:0]),
        .op_i (sh_op),
        .c_i  (flags_q[FLAG_C]),
        .q_o  (sh_q),
        .c_o  (sh_c)
    );

    always_comb begin
        // Only ADC/SBC chain the carry flag; the immediate forms start from zero
        cin_add = (iOP == OP_ADC) ? flags_q[FLAG_C] : 1'b0;
        cin_sub = (iOP == OP_SBC) ? flags_q[FLAG_C] : 1'b0;
        add_w   = {1'b0, iA} + {1'b0, iB} + {{BW{1'b0}}, cin_add};
        // Bit BW of the difference is the borrow
        sub_w   = {1'b0, iA} - {1'b0, iB} - {{BW{1'b0}}, cin_sub};

        alu_q = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (iOP)
            OP_MOV, OP_MVI: alu_q = iB;
            OP_MVN: begin
                alu_q = ~iB;
                alu_c = 1'b1;
            end
            OP_ADC, OP_ADI: begin
                alu_q = add_w[BW-1:0];
                alu_c = add_w[BW];
                alu_v = ~(iA[BW-1] ^ iB[BW-1]) & (iA[BW-1] ^ add_w[BW-1]);
            end
            OP_SBC, OP_SBI: begin
                alu_q = sub_w[BW-1:0];
                alu_c = sub_w[BW];
                alu_v = (iA[BW-1] ^ iB[BW-1]) & (iA[BW-1] ^ sub_w[BW-1]);
            end
            OP_AND: alu_q = iA & iB;
            OP_ORR: alu_q = iA | iB;
            OP_XOR: alu_q = iA ^ iB;
            OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
                alu_q = sh_q;
                alu_c = sh_c;
            end
            // NOP, and MUL when it is not sequenced, produce zero with C=0
            default: ;
        endcase

        flags_d         = '0;
        flags_d[FLAG_N] = alu_q[BW-1];
        flags_d[FLAG_Z] = (alu_q == '0);
        flags_d[FLAG_C] = alu_c;
        flags_d[FLAG_V] = alu_v;
    end

    assign accept = iVALID & oREADY;

`ifdef GPPCU_ALU_MUL_EN
    state_e          state_q;
    logic [SW-1:0]   cnt_q;
    logic [2*BW-1:0] acc_q;
    logic [2*BW-1:0] acc_d;
    logic [2*BW-1:0] mcand_q;
    logic [BW-1:0]   mplier_q;
    logic            setf_q;
    logic            mul_last;
    logic [3:0]      mul_flags;

    // Shift-add: one multiplier bit per cycle, multiplicand walks left
    always_comb begin
        acc_d              = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_last           = (state_q == ST_MUL) && (cnt_q == SW'(BW - 1));
        mul_flags          = '0;
        mul_flags[FLAG_N]  = acc_d[BW-1];
        mul_flags[FLAG_Z]  = (acc_d[BW-1:0] == '0);
        mul_flags[FLAG_C]  = |acc_d[2*BW-1:BW];
    end

    assign oREADY = (state_q == ST_IDLE) & (~vld_q | iREADY);
    assign oBUSY  = (state_q == ST_MUL);
`else
    assign oREADY = ~vld_q | iREADY;
    assign oBUSY  = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iNRST) begin
        if (!iNRST) begin
            q_q      <= '0;
            vld_q    <= 1'b0;
            flags_q  <= '0;
`ifdef GPPCU_ALU_MUL_EN
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            setf_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
`ifdef GPPCU_ALU_MUL_EN
                if (iOP == OP_MUL) begin
                    // Any previous result drains on this edge (oREADY implied iREADY)
                    state_q  <= ST_MUL;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    mcand_q  <= {{BW{1'b0}}, iA};
                    mplier_q <= iB;
                    setf_q   <= iSETF;
                    vld_q    <= 1'b0;
                end else
`endif
                begin
                    q_q   <= alu_q;
                    vld_q <= 1'b1;
                    if (iSETF) begin
                        flags_q <= flags_d;
                    end
                end
            end else if (iREADY) begin
                vld_q <= 1'b0;
            end

`ifdef GPPCU_ALU_MUL_EN
            // No accept can coincide with MUL, so these writes never collide with the above
            if (state_q == ST_MUL) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + SW'(1);
                if (mul_last) begin
                    state_q <= ST_IDLE;
                    q_q     <= acc_d[BW-1:0];
                    vld_q   <= 1'b1;
                    if (setf_q) begin
                        flags_q <= mul_flags;
                    end
                end
            end
`endif
        end
    end

    assign oQ     = q_q;
    assign oVALID = vld_q;
    assign oN     = flags_q[FLAG_N];
    assign oZ     = flags_q[FLAG_Z];
    assign oC     = flags_q[FLAG_C];
    assign oV     = flags_q[FLAG_V];

endmodule

// File: tb/tb_gppcu_alu_seq.sv
// Self-checking bench for gppcu_alu_seq: directed steps then random ops vs a reference model.
// Latency and hold behaviour are checked directly; the model only predicts results and flags.
// Backpressure is exercised by holding iREADY low across a pending result.
module tb_gppcu_alu_seq;

    localparam int BW = 32;

    localparam logic [3:0] NOP = 4'd0,  MOV = 4'd1,  MVN = 4'd2,  ADC = 4'd3;
    localparam logic [3:0] SBC = 4'd4,  AND = 4'd5,  ORR = 4'd6,  XOR = 4'd7;
    localparam logic [3:0] ADI = 4'd8,  SBI = 4'd9,  MVI = 4'd10, LSL = 4'd11;
    localparam logic [3:0] LSR = 4'd12, ASR = 4'd13, MUL = 4'd14, ROR = 4'd15;

    logic          iCLK = 1'b0;
    logic          iNRST;
    logic          iVALID;
    logic          oREADY;
    logic [3:0]    iOP;
    logic [BW-1:0] iA;
    logic [BW-1:0] iB;
    logic          iSETF;
    logic          oVALID;
    logic          iREADY;
    logic [BW-1:0] oQ;
    logic          oN, oZ, oC, oV;
    logic          oBUSY;

    gppcu_alu_seq #(.BW(BW)) dut (
        .iCLK   (iCLK),
        .iNRST  (iNRST),
        .iVALID (iVALID),
        .oREADY (oREADY),
        .iOP    (iOP),
        .iA     (iA),
        .iB     (iB),
        .iSETF  (iSETF),
        .oVALID (oVALID),
        .iREADY (iREADY),
        .oQ     (oQ),
        .oN     (oN),
        .oZ     (oZ),
        .oC     (oC),
        .oV     (oV),
        .oBUSY  (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int n_total = 0;
    int n_pass  = 0;

    logic [3:0]    ef;   // expected {N,Z,C,V}
    logic [BW-1:0] eq;   // expected result of the last accepted op

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic signed_ovf(input longint ss);
        return (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    endfunction

    // Returns {Q, N, Z, C, V}
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] f);
        logic [31:0] q = '0;
        logic [31:0] x;
        logic        c = 1'b0;
        logic        v = 1'b0;
        longint      s;
        logic [63:0] p;
        int          n;
        logic        cf = f[1];
        case (op)
            MOV, MVI: q = b;
            MVN: begin q = ~b; c = 1'b1; end
            ADC, ADI: begin
                s = longint'(a) + longint'(b) + ((op == ADC) ? longint'(cf) : 64'sd0);
                q = s[31:0];
                c = s[32];
                v = signed_ovf(longint'($signed(a)) + longint'($signed(b))
                               + ((op == ADC) ? longint'(cf) : 64'sd0));
            end
            SBC, SBI: begin
                s = longint'(a) - longint'(b) - ((op == SBC) ? longint'(cf) : 64'sd0);
                q = s[31:0];
                c = (s < 0);
                v = signed_ovf(longint'($signed(a)) - longint'($signed(b))
                               - ((op == SBC) ? longint'(cf) : 64'sd0));
            end
            AND: q = a & b;
            ORR: q = a | b;
            XOR: q = a ^ b;
            LSL, LSR, ASR, ROR: begin
                n = int'(b[4:0]);
                x = a;
                c = cf;
                for (int i = 0; i < n; i++) begin
                    case (op)
                        LSL: begin c = x[31]; x = {x[30:0], 1'b0}; end
                        LSR: begin c = x[0];  x = {1'b0, x[31:1]}; end
                        ASR: begin c = x[0];  x = {x[31], x[31:1]}; end
                        default: x = {x[0], x[31:1]};
                    endcase
                end
                if (op == ROR && n > 0) c = x[31];
                q = x;
            end
`ifdef GPPCU_ALU_MUL_EN
            MUL: begin
                p = {32'b0, a} * {32'b0, b};
                q = p[31:0];
                c = (p[63:32] != 0);
            end
`endif
            default: ;
        endcase
        return {q, q[31], (q == 0), c, v};
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge with iVALID still high.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic setf);
        logic [35:0] r;
        int w = 0;
        while (!oREADY && w < 200) begin
            @(posedge iCLK); #1; w++;
        end
        check("send_ready", oREADY, 1);
        iVALID = 1'b1; iOP = op; iA = a; iB = b; iSETF = setf;
        r  = model(op, a, b, ef);
        eq = r[35:4];
        if (setf) ef = r[3:0];
        @(posedge iCLK); #1;
    endtask

    task automatic wait_result(input string tag);
        int w = 0;
        while (!oVALID && w < 200) begin
            @(posedge iCLK); #1; w++;
        end
        check({tag, "_vld"}, oVALID, 1);
        check({tag, "_q"}, oQ, eq);
        check({tag, "_flags"}, {oN, oZ, oC, oV}, ef);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic setf);
        send(op, a, b, setf);
        iVALID = 1'b0;
        wait_result(tag);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [3:0]  fprev;
        int          w;

        iNRST = 1'b0; iVALID = 1'b0; iREADY = 1'b1; iOP = '0; iA = '0; iB = '0; iSETF = 1'b0;
        ef = '0; eq = '0;
        #2;
        check("rst_q", oQ, 0);
        check("rst_vld", oVALID, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_flags", {oN, oZ, oC, oV}, 4'b0000);
        @(posedge iCLK); #1;
        iNRST = 1'b1;
        @(posedge iCLK); #1;
        check("rst_ready", oREADY, 1);

        // Carry out of ADI chains into a back-to-back ADC
        send(ADI, 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("tp1_q", oQ, 0);
        check("tp1_flags", {oN, oZ, oC, oV}, 4'b0110);
        send(ADC, 32'd0, 32'd0, 1'b1);
        iVALID = 1'b0;
        check("tp2_adc_q", oQ, 1);
        wait_result("tp2_adc");

        // Output held under backpressure; a competing op is not taken
        @(posedge iCLK); #1;
        check("drain_vld", oVALID, 0);
        iREADY = 1'b0;
        send(MOV, 32'd0, 32'h1234_5678, 1'b0);
        iOP = MVN; iB = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check("hold_vld", oVALID, 1);
            check("hold_q", oQ, 32'h1234_5678);
            check("hold_rdy", oREADY, 0);
            @(posedge iCLK); #1;
        end
        iVALID = 1'b0;
        iREADY = 1'b1;
        @(posedge iCLK); #1;
        check("release_vld", oVALID, 0);

        // Signed overflow in both directions
        run_op("tp3_sbi", SBI, 32'h8000_0000, 32'd1, 1'b1);
        check("tp3_sbi_q", oQ, 32'h7FFF_FFFF);
        check("tp3_sbi_nzcv", {oN, oZ, oC, oV}, 4'b0001);
        run_op("tp3_adi", ADI, 32'h7FFF_FFFF, 32'd1, 1'b1);
        check("tp3_adi_q", oQ, 32'h8000_0000);
        check("tp3_adi_nzcv", {oN, oZ, oC, oV}, 4'b1001);

        // Shifts; B=32 gives amount 0, which keeps the carry
        run_op("tp4_asr", ASR, 32'h8000_0001, 32'd1, 1'b1);
        check("tp4_asr_q", oQ, 32'hC000_0000);
        check("tp4_asr_c", oC, 1);
        run_op("tp4_lsl0", LSL, 32'h0000_0055, 32'd32, 1'b1);
        check("tp4_lsl0_q", oQ, 32'h0000_0055);
        check("tp4_lsl0_c", oC, 1);
        run_op("tp4_ror", ROR, 32'd1, 32'd4, 1'b1);
        check("tp4_ror_q", oQ, 32'h1000_0000);
        run_op("tp4_lsl31", LSL, 32'h0000_0003, 32'd31, 1'b1);
        run_op("tp4_lsr", LSR, 32'h8000_0003, 32'd2, 1'b1);

        // Ops without iSETF leave the flags alone
        run_op("tp6_mvn", MVN, 32'd0, 32'd0, 1'b1);
        fprev = ef;
        run_op("tp6_xor", XOR, 32'd5, 32'd5, 1'b0);
        check("tp6_xor_q", oQ, 0);
        check("tp6_xor_flags", {oN, oZ, oC, oV}, fprev);

`ifdef GPPCU_ALU_MUL_EN
        send(MUL, 32'd3, 32'd5, 1'b1);
        iVALID = 1'b0;
        check("mul_busy", oBUSY, 1);
        check("mul_rdy", oREADY, 0);
        w = 0;
        while (!oVALID && w < 200) begin
            check("mul_busy_iter", oBUSY, 1);
            @(posedge iCLK); #1; w++;
        end
        check("mul_latency", w + 1, BW + 1);
        wait_result("mul_3x5");
        check("mul_3x5_q", oQ, 15);
        check("mul_3x5_c", oC, 0);
        check("mul_done_busy", oBUSY, 0);
        run_op("mul_hi", MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
        check("mul_hi_zc", {oZ, oC}, 2'b11);
        // Reset in the middle of a multiply discards it
        send(MUL, 32'd7, 32'd9, 1'b1);
        iVALID = 1'b0;
        repeat (5) @(posedge iCLK);
        #1;
        check("mul_mid_busy", oBUSY, 1);
        iNRST = 1'b0;
        #1;
        check("mul_rst_vld", oVALID, 0);
        check("mul_rst_busy", oBUSY, 0);
        check("mul_rst_flags", {oN, oZ, oC, oV}, 4'b0000);
        ef = '0;
        @(posedge iCLK); #1;
        iNRST = 1'b1;
        @(posedge iCLK); #1;
        check("mul_rst_ready", oREADY, 1);
`else
        run_op("op14_nop", MUL, 32'd3, 32'd5, 1'b1);
        check("op14_q", oQ, 0);
        check("op14_busy", oBUSY, 0);
`endif

        // Random ops against the model, carries chained through the flag register
        for (int k = 0; k < 300; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFF_FFFF};
            run_op("rnd", op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
